sha_message_schedule_ctrl: RTL and testbench
============================================

// Module: sha_message_schedule_ctrl
// PURPOSE
//  Sequences one SHA-256 message block through the pipelined message expander (sha_message_expander_pipeline).
//  - Accepts a 16-word block and emits the 64-word schedule W0..W63 in order, one word per output handshake.
//  - Holds the 16-word history register and feeds it to the expander, which has no enable.
//  - Times each capture against the expander's fixed latency.
//  - Sits between the block loader and the compression-round core.
// PARAMETERS
//  PIPELINE_DEPTH  3   expander register stages (>=1); also the wait count per expanded word
// PORTS
//  clk           in   1        clock
//  rst_n         in   1        asynchronous active-low reset
//  blk_valid_i   in   1        block offered
//  blk_ready_o   out  1        block accepted when valid&ready
//  blk_i         in   16x32    message words; blk_i[0]=M0 .. blk_i[15]=M15
//  sched_valid_o out  1        sched_w_o holds W_t
//  sched_ready_i in   1        consumer takes word when valid&ready
//  sched_w_o     out  32       schedule word W_t
//  sched_round_o out  6        t of the presented word (0..63)
//  sched_last_o  out  1        high with W63
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, history 0, round 0, wait counter 0. Reset mid-block abandons the block; no partial resume.
//  States:
//  - IDLE: blk_ready_o=1; on accept load hist[i]=blk_i[15-i], round=0, wcnt=PIPELINE_DEPTH, go MSG. Ready is high only in IDLE.
//  - MSG (t=0..15): sched_valid_o=1, sched_w_o=hist[15-t]; round increments on handshake; handshake at t=15 -> EXP.
//  - EXP (t=16..63): expander input = hist, held stable between captures. wcnt decrements to 0 each cycle, independent of stalls.
//      Capture when wcnt==0 AND (!sched_valid_o OR sched_ready_i): hist<=expander W_o, present W_o[0] as W_t, wcnt<=PIPELINE_DEPTH.
//      Handshake of W63 -> IDLE the next cycle; sched_valid_o drops unless re-captured.
//  Latency/throughput:
//  - First word is valid the cycle after block accept.
//  - W16 is valid the cycle after the W15 handshake; the wait counter runs during MSG, so W16 is ready once PIPELINE_DEPTH<=16.
//  - With sched_ready_i tied high, steady state is one expanded word per PIPELINE_DEPTH+1 cycles.
//  Stall: valid&!ready holds sched_w_o, sched_round_o and sched_last_o stable. W_o stays valid because hist is unchanged.
//  Arithmetic: round is a 6-bit counter that never wraps within a block (63 -> IDLE). wcnt is $clog2(PIPELINE_DEPTH+1) bits and saturates at 0.
//  Word math is mod 2^32 inside the expander; the controller does none.
//  sched_last_o = sched_valid_o && round==63.
// CONFIGURATION
//  SHA_SCHED_PERF_EN defined:
//  - Adds out ports perf_blocks_o[31:0] (W63 handshakes) and perf_stall_o[31:0] (cycles with valid&!ready).
//  - Both wrap mod 2^32 and reset to 0.
//  SHA_SCHED_PERF_EN undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  sha_pkg: typedef logic[31:0] word_t; typedef word_t[15:0] block_t;
//           localparam SHA_ROUNDS=64, SHA_BLOCK_WORDS=16; enum sched_state_e {IDLE,MSG,EXP}.
//  One sub-module instance: sha_message_expander_pipeline #(PIPELINE_DEPTH) with W_i=hist and W_o to the capture mux.
//  FSM, round counter, wait counter and history register are local.
// TESTING
//  1 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), ready high ->
//    W0=0x61626380, W15=0x18, W16=0x61626380, W17=0x000F0000, W18=0x7DA86405;
//    all 64 words match the C model; sched_last_o only at t=63.
//  2 Random sched_ready_i (50%) over 20 random blocks -> word stream identical to case 1 model;
//    outputs never change while valid&!ready.
//  3 PIPELINE_DEPTH=1,3,8 ->
//    correct words for each depth; gap between W16..W63 handshakes with ready high = PIPELINE_DEPTH+1 cycles.
//  4 blk_valid_i held high across a whole block ->
//    second block accepted only in IDLE after W63 handshake; blk_ready_o=0 throughout MSG/EXP.
//  5 rst_n asserted at t=30 mid-stall ->
//    outputs 0 immediately (async); after release, a new block restarts at t=0 with correct words.
//  6 SHA_SCHED_PERF_EN, 3 blocks with 7 stall cycles -> perf_blocks_o=3, perf_stall_o=7.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA-256 message-schedule types, sizes and small-sigma helpers.
// No timing of its own; pure declarations and combinational functions.
// No handshake; used by the controller, its interface and the expander.
package sha_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [15:0] block_t;

    localparam int SHA_ROUNDS      = 64;
    localparam int SHA_BLOCK_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        EXP  = 2'd2
    } sched_state_e;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_message_schedule_ctrl_if.sv
// Block-in / schedule-word-out bundle between loader, scheduler and round core.
// No timing of its own; signal names carry the scheduler's direction suffix.
// Both sides use valid/ready; a transfer happens when valid & ready.
interface sha_message_schedule_ctrl_if;
    import sha_pkg::*;

    logic        blk_valid_i;
    logic        blk_ready_o;
    block_t      blk_i;
    logic        sched_valid_o;
    logic        sched_ready_i;
    word_t       sched_w_o;
    logic [5:0]  sched_round_o;
    logic        sched_last_o;

    // Loader + round core side.
    modport master (
        output blk_valid_i, blk_i, sched_ready_i,
        input  blk_ready_o, sched_valid_o, sched_w_o, sched_round_o, sched_last_o
    );

    // Scheduler side.
    modport slave (
        input  blk_valid_i, blk_i, sched_ready_i,
        output blk_ready_o, sched_valid_o, sched_w_o, sched_round_o, sched_last_o
    );

endinterface

// File: rtl/sha_message_schedule_ctrl_expander.sv
// Computes the next 16-word schedule window (new word at index 0) from the current one.
// Latency PIPELINE_DEPTH cycles, fully pipelined, no enable.
// No backpressure: the caller must hold W_i stable for PIPELINE_DEPTH cycles.
module sha_message_expander_pipeline
    import sha_pkg::*;
#(
    parameter int PIPELINE_DEPTH = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    input  block_t W_i,
    output block_t W_o
);

    block_t win_d;
    block_t pipe_q [PIPELINE_DEPTH];

    // W_i[k] is W(t-1-k): shift the window one place and put W(t) at the bottom.
    always_comb begin
        win_d = {W_i[14:0], sigma1(W_i[1]) + W_i[6] + sigma0(W_i[14]) + W_i[15]};
    end

    // Delay line that models the expander's register stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < PIPELINE_DEPTH; s++) pipe_q[s] <= '0;
        end else begin
            pipe_q[0] <= win_d;
            for (int s = 1; s < PIPELINE_DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign W_o = pipe_q[PIPELINE_DEPTH-1];

endmodule

// File: rtl/sha_message_schedule_ctrl.sv
// Streams W0..W63 of one SHA-256 block: W0..W15 from history, W16..W63 via the pipelined expander.
// First word one cycle after block accept; expanded words every PIPELINE_DEPTH+1 cycles when unstalled.
// Holds the presented word under sched_ready_i low; blk_ready_o only in IDLE. Option: SHA_SCHED_PERF_EN.
module sha_message_schedule_ctrl
    import sha_pkg::*;
#(
    parameter int PIPELINE_DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    sha_message_schedule_ctrl_if.slave bus
`ifdef SHA_SCHED_PERF_EN
    ,
    output logic [31:0] perf_blocks_o,
    output logic [31:0] perf_stall_o
`endif
);

    localparam int WCNT_W = $clog2(PIPELINE_DEPTH + 1);
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(PIPELINE_DEPTH);
    localparam logic [5:0] LAST_ROUND = 6'(SHA_ROUNDS - 1);
    localparam logic [5:0] LAST_MSG   = 6'(SHA_BLOCK_WORDS - 1);

    sched_state_e      state_q, state_d;
    block_t            hist_q, hist_d;
    logic [5:0]        round_q, round_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              vld_q, vld_d;
    word_t             w_q, w_d;
    logic              ready_q, ready_d;

    block_t exp_w;
    logic   accept, hs, last_word, cap;

    sha_message_expander_pipeline #(
        .PIPELINE_DEPTH(PIPELINE_DEPTH)
    ) u_expander (
        .clk   (clk),
        .rst_n (rst_n),
        .W_i   (hist_q),
        .W_o   (exp_w)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: block accept, W15 handshake, W63 handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = MSG;
            MSG:     if (hs && round_q == LAST_MSG) state_d = EXP;
            EXP:     if (hs && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake decode and capture qualification; capture may also fire on the W15 handshake.
    always_comb begin
        accept    = bus.blk_valid_i && ready_q;
        hs        = vld_q && bus.sched_ready_i;
        last_word = (round_q == LAST_ROUND);
        cap       = 1'b0;
        if (wcnt_q == '0 && (!vld_q || bus.sched_ready_i)) begin
            if (state_q == EXP)
                cap = !(hs && last_word);
            else if (state_q == MSG)
                cap = hs && (round_q == LAST_MSG);
        end
        bus.sched_last_o = vld_q && last_word;
    end

    // Datapath next-state: history load/capture, round advance on handshake, latency countdown.
    always_comb begin
        hist_d  = hist_q;
        round_d = round_q;
        vld_d   = vld_q;
        w_d     = w_q;
        wcnt_d  = (wcnt_q != '0) ? wcnt_q - 1'b1 : '0;
        if (accept) begin
            for (int i = 0; i < SHA_BLOCK_WORDS; i++) hist_d[i] = bus.blk_i[15-i];
            round_d = '0;
            wcnt_d  = WCNT_LOAD;
            vld_d   = 1'b1;
            w_d     = bus.blk_i[0];
        end else if (hs) begin
            if (state_q == MSG && round_q != LAST_MSG) begin
                w_d     = hist_q[4'd14 - round_q[3:0]];
                round_d = round_q + 6'd1;
            end else begin
                vld_d   = 1'b0;
                round_d = last_word ? 6'd0 : round_q + 6'd1;
            end
        end
        if (cap) begin
            hist_d = exp_w;
            w_d    = exp_w[0];
            vld_d  = 1'b1;
            wcnt_d = WCNT_LOAD;
        end
        ready_d = (state_d == IDLE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            round_q <= '0;
            wcnt_q  <= '0;
            vld_q   <= 1'b0;
            w_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            round_q <= round_d;
            wcnt_q  <= wcnt_d;
            vld_q   <= vld_d;
            w_q     <= w_d;
            ready_q <= ready_d;
        end
    end

    assign bus.blk_ready_o   = ready_q;
    assign bus.sched_valid_o = vld_q;
    assign bus.sched_w_o     = w_q;
    assign bus.sched_round_o = round_q;

`ifdef SHA_SCHED_PERF_EN
    logic [31:0] perf_blocks_q, perf_stall_q;

    // Completed blocks and stalled-output cycles, both free-running mod 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_blocks_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (hs && last_word) perf_blocks_q <= perf_blocks_q + 32'd1;
            if (vld_q && !bus.sched_ready_i) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_blocks_o = perf_blocks_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_sha_message_schedule_ctrl.sv
// Self-checking bench for sha_message_schedule_ctrl: known "abc" vectors, random blocks
// with random backpressure against a plain-arithmetic SHA-256 schedule model, depth variants,
// back-to-back offers and asynchronous reset mid-stall.
module tb_sha_message_schedule_ctrl;
    import sha_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rmode = 1;   // 0: ready low, 1: ready high, 2: random ready

    always @(posedge clk) cyc++;

    sha_message_schedule_ctrl_if bus();
`ifdef SHA_SCHED_PERF_EN
    logic [31:0] perf_blocks, perf_stall;
`endif

    sha_message_schedule_ctrl #(.PIPELINE_DEPTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SHA_SCHED_PERF_EN
        ,
        .perf_blocks_o (perf_blocks),
        .perf_stall_o  (perf_stall)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    word_t ref_w [64];
    word_t exp_w [$];

    function automatic word_t rr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic calc(input block_t m);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) ref_w[t] = m[t];
            else ref_w[t] = (rr(ref_w[t-2], 17) ^ rr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                          + ref_w[t-7]
                          + (rr(ref_w[t-15], 7) ^ rr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                          + ref_w[t-16];
        end
    endtask

    task automatic push_expected(input block_t m);
        calc(m);
        for (int t = 0; t < 64; t++) exp_w.push_back(ref_w[t]);
    endtask

    function automatic block_t rand_block();
        block_t b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction

    function automatic block_t abc_block();
        block_t b;
        b = '0;
        b[0]  = 32'h61626380;
        b[15] = 32'h00000018;
        return b;
    endfunction

    // ---------------- monitor ----------------
    word_t rec_w [$];
    int    rec_t [$];
    bit    rec_last [$];
    int    rec_cyc [$];
    int    acc_cyc [$];
    bit    p_ok = 1'b0;
    logic  p_vld, p_rdy, p_last;
    word_t p_w;
    logic [5:0] p_t;
    int    m_blocks = 0;
    int    m_stalls = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_ok = 1'b0;
            m_blocks = 0;
            m_stalls = 0;
        end else begin
            if (p_ok && p_vld && !p_rdy) begin
                chk("stall_valid", bus.sched_valid_o, 1);
                chk("stall_word", bus.sched_w_o, p_w);
                chk("stall_round", bus.sched_round_o, p_t);
                chk("stall_last", bus.sched_last_o, p_last);
            end
            if (bus.sched_valid_o) chk("blk_ready_busy", bus.blk_ready_o, 0);
            if (bus.blk_valid_i && bus.blk_ready_o) acc_cyc.push_back(cyc);
            if (bus.sched_valid_o && bus.sched_ready_i) begin
                rec_w.push_back(bus.sched_w_o);
                rec_t.push_back(int'(bus.sched_round_o));
                rec_last.push_back(bus.sched_last_o);
                rec_cyc.push_back(cyc);
                if (bus.sched_round_o == 6'd63) m_blocks++;
            end
            if (bus.sched_valid_o && !bus.sched_ready_i) m_stalls++;
            p_ok = 1'b1;
            p_vld = bus.sched_valid_o; p_rdy = bus.sched_ready_i;
            p_w = bus.sched_w_o; p_t = bus.sched_round_o; p_last = bus.sched_last_o;
        end
    end

    // Consumer ready driver.
    initial begin
        bus.sched_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       bus.sched_ready_i = 1'b0;
                1:       bus.sched_ready_i = 1'b1;
                default: bus.sched_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- depth variants (ready tied high, one "abc" block each) ----------------
    for (genvar g = 0; g < 2; g++) begin : g_dep
        localparam int D = (g == 0) ? 1 : 8;
        sha_message_schedule_ctrl_if ifc();
`ifdef SHA_SCHED_PERF_EN
        logic [31:0] pb, ps;
`endif
        sha_message_schedule_ctrl #(.PIPELINE_DEPTH(D)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ifc)
`ifdef SHA_SCHED_PERF_EN
            ,
            .perf_blocks_o (pb),
            .perf_stall_o  (ps)
`endif
        );
        word_t w [64];
        int    c [64];
        int    n = 0;

        initial begin
            ifc.blk_valid_i   = 1'b0;
            ifc.blk_i         = '0;
            ifc.sched_ready_i = 1'b1;
            wait (rst_n === 1'b1);
            @(posedge clk); #1;
            ifc.blk_valid_i = 1'b1;
            ifc.blk_i       = abc_block();
            for (int i = 0; i < 50 && !ifc.blk_ready_o; i++) @(negedge clk);
            @(posedge clk); #1;
            ifc.blk_valid_i = 1'b0;
        end

        always @(negedge clk)
            if (rst_n && ifc.sched_valid_o && ifc.sched_ready_i && n < 64) begin
                w[n] = ifc.sched_w_o;
                c[n] = cyc;
                n++;
            end
    end

    task automatic check_depth(input string nm, input int d, input int n,
                               input word_t w [64], input int c [64]);
        calc(abc_block());
        chk({nm, "_count"}, n, 64);
        if (n == 64) begin
            for (int t = 0; t < 64; t++) chk({nm, "_word"}, w[t], ref_w[t]);
            for (int t = 17; t < 64; t++) chk({nm, "_gap"}, c[t] - c[t-1], d + 1);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_rec();
        rec_w.delete(); rec_t.delete(); rec_last.delete(); rec_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic send(input block_t b);
        bit ok = 1'b0;
        @(posedge clk); #1;
        bus.blk_valid_i = 1'b1;
        bus.blk_i       = b;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (bus.blk_ready_o) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.blk_valid_i = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && rec_w.size() < n; i++) @(negedge clk);
        if (rec_w.size() < n) chk("words_timeout", rec_w.size(), n);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 3000 && acc_cyc.size() < n; i++) @(negedge clk);
        if (acc_cyc.size() < n) chk("accept_count_timeout", acc_cyc.size(), n);
    endtask

    task automatic compare_stream(input string nm);
        int n;
        chk({nm, "_len"}, rec_w.size(), exp_w.size());
        n = (rec_w.size() < exp_w.size()) ? rec_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk({nm, "_word"}, rec_w[i], exp_w[i]);
            chk({nm, "_round"}, rec_t[i], i % 64);
            chk({nm, "_last"}, rec_last[i], (i % 64) == 63);
        end
        exp_w.delete();
    endtask

    typedef struct {
        int    t;
        word_t w;
    } vec_t;
    vec_t vt [5];

    // ---------------- main sequence ----------------
    initial begin
        vt[0] = '{0,  32'h61626380};
        vt[1] = '{15, 32'h00000018};
        vt[2] = '{16, 32'h61626380};
        vt[3] = '{17, 32'h000F0000};
        vt[4] = '{18, 32'h7DA86405};

        bus.blk_valid_i = 1'b0;
        bus.blk_i       = '0;
        rmode           = 1;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.sched_valid_o, 0);
        chk("rst_ready", bus.blk_ready_o, 0);
        chk("rst_word", bus.sched_w_o, 0);
        chk("rst_round", bus.sched_round_o, 0);
        chk("rst_last", bus.sched_last_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", bus.blk_ready_o, 1);

        // "abc" block, ready high
        clear_rec();
        push_expected(abc_block());
        send(abc_block());
        wait_words(64, 2000);
        if (rec_w.size() >= 64) begin
            for (int k = 0; k < 5; k++) chk($sformatf("abc_W%0d", vt[k].t), rec_w[vt[k].t], vt[k].w);
            chk("first_word_latency", rec_cyc[0] - acc_cyc[0], 1);
            chk("w16_after_w15", rec_cyc[16] - rec_cyc[15], 1);
            for (int t = 17; t < 64; t++) chk("d3_gap", rec_cyc[t] - rec_cyc[t-1], 4);
        end
        compare_stream("abc");

        // 20 random blocks with random backpressure
        clear_rec();
        rmode = 2;
        for (int k = 0; k < 20; k++) begin
            block_t b;
            b = rand_block();
            push_expected(b);
            send(b);
        end
        wait_words(64 * 20, 20000);
        compare_stream("rand");

        // block offer held high across a whole block
        rmode = 1;
        clear_rec();
        begin
            block_t a, b;
            a = rand_block();
            b = rand_block();
            push_expected(a);
            push_expected(b);
            @(posedge clk); #1;
            bus.blk_valid_i = 1'b1;
            bus.blk_i       = a;
            wait_acc(1);
            @(posedge clk); #1;
            bus.blk_i = b;
            wait_acc(2);
            @(posedge clk); #1;
            bus.blk_valid_i = 1'b0;
            wait_words(128, 3000);
            if (rec_cyc.size() >= 64 && acc_cyc.size() >= 2)
                chk("second_accept_after_w63", acc_cyc[1] - rec_cyc[63], 1);
            compare_stream("b2b");
        end

        // depth variants
        check_depth("d1", 1, g_dep[0].n, g_dep[0].w, g_dep[0].c);
        check_depth("d8", 8, g_dep[1].n, g_dep[1].w, g_dep[1].c);

        // asynchronous reset while stalled on W30
        clear_rec();
        begin
            block_t b;
            b = rand_block();
            send(b);
            wait_words(30, 2000);
            rmode = 0;
            repeat (10) @(negedge clk);
            chk("stall_w30_valid", bus.sched_valid_o, 1);
            chk("stall_w30_round", bus.sched_round_o, 30);
            #2;
            rst_n = 1'b0;
            #1;
            chk("arst_valid", bus.sched_valid_o, 0);
            chk("arst_ready", bus.blk_ready_o, 0);
            chk("arst_word", bus.sched_w_o, 0);
            chk("arst_round", bus.sched_round_o, 0);
            chk("arst_last", bus.sched_last_o, 0);
            exp_w.delete();
            repeat (2) @(negedge clk);
            clear_rec();
            @(posedge clk); #1;
            rst_n = 1'b1;
            rmode = 1;
            b = rand_block();
            push_expected(b);
            send(b);
            wait_words(64, 2000);
            compare_stream("post_rst");
        end

`ifdef SHA_SCHED_PERF_EN
        // three blocks with exactly seven stalled cycles, counted from a fresh reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_rec();
        for (int k = 0; k < 3; k++) begin
            block_t b;
            b = rand_block();
            push_expected(b);
            send(b);
            if (k == 1) begin
                wait_words(64 + 20, 2000);
                @(posedge clk); #1;
                rmode = 0;
                repeat (7) @(posedge clk);
                #1;
                rmode = 1;
            end
        end
        wait_words(192, 3000);
        compare_stream("perf");
        repeat (3) @(negedge clk);
        chk("perf_blocks", perf_blocks, 3);
        chk("perf_stall", perf_stall, m_stalls);
        chk("perf_stall_seven", m_stalls, 7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
